// File: rtl/insertunit_if.sv
// Scalar-in / vector-out handshake bundle for insertunit.
// The slave modport is the unit side; the master modport is the producer/consumer side.
interface insertunit_if #(
  parameter int unsigned K = 4,
  parameter int unsigned W = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [31:0]    in_index;
  logic           in_bcast;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [K*W-1:0] out_data;
  logic [K-1:0]   out_mask;
  logic           err_oob;

  modport slave (
    input  in_valid, in_data, in_index, in_bcast, in_last, out_ready,
    output in_ready, out_valid, out_data, out_mask, err_oob
  );

  modport master (
    output in_valid, in_data, in_index, in_bcast, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_mask, err_oob
  );
endinterface

// File: rtl/insertunit.sv
// Assembles tagged 32-bit scalar words into a K-lane vector and hands it off via valid/ready.
// Optional INSERTUNIT_ZERO_FILL_EN clears the lane buffer after each delivered vector.
module insertunit #(
  parameter int unsigned K = 4,
  parameter int unsigned W = 32
) (
  input  logic          clk,
  input  logic          reset,
  insertunit_if.slave   bus
);
  localparam int unsigned LW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t              r_state;
  logic [K-1:0][W-1:0] r_buf;
  logic [K-1:0]        r_mask;
  logic                r_err_oob;
  logic                r_in_ready;
  logic                r_out_valid;

  logic [LW-1:0]       w_lane;
  logic                w_in_range;

  assign w_lane     = bus.in_index[LW-1:0];
  assign w_in_range = (bus.in_index < 32'(K));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= FILL;
      r_buf       <= '0;
      r_mask      <= '0;
      r_err_oob   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_err_oob <= 1'b0;
      case (r_state)
        FILL: begin
          if (bus.in_valid) begin
            if (bus.in_bcast) begin
              r_buf  <= {K{bus.in_data}};
              r_mask <= '1;
            end else if (w_in_range) begin
              r_buf[w_lane]  <= bus.in_data;
              r_mask[w_lane] <= 1'b1;
            end else begin
              r_err_oob <= 1'b1;
            end
            // Out-of-range words still close the vector.
            if (bus.in_last) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_state     <= FILL;
            r_mask      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef INSERTUNIT_ZERO_FILL_EN
            r_buf       <= '0;
`endif
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_buf;
  assign bus.out_mask  = r_mask;
  assign bus.err_oob   = r_err_oob;
endmodule

// File: tb/tb_insertunit.sv
// Directed plus random bench for insertunit against a lane-array reference model.
module tb_insertunit;
  localparam int unsigned K = 4;
  localparam int unsigned W = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  insertunit_if #(.K(K), .W(W)) bus ();

  insertunit #(.K(K), .W(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: lane contents, fresh-lane set, and whether a vector is waiting.
  logic [W-1:0] m_lanes [K];
  logic [K-1:0] m_mask;
  logic         m_hold;
  logic         m_err;
  int           m_delivered;

  function automatic logic [K*W-1:0] m_vec();
    logic [K*W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(K); i++) v[i*W +: W] = m_lanes[i];
    return v;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_hold = 1'b0;
      m_mask = '0;
      m_err  = 1'b0;
      for (int i = 0; i < int'(K); i++) m_lanes[i] = '0;
    end else begin
      m_err = 1'b0;
      if (!m_hold && bus.in_valid) begin
        if (bus.in_bcast) begin
          for (int i = 0; i < int'(K); i++) m_lanes[i] = bus.in_data;
          m_mask = '1;
        end else if (bus.in_index < K) begin
          m_lanes[bus.in_index] = bus.in_data;
          m_mask[bus.in_index] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        if (bus.in_last) m_hold = 1'b1;
      end else if (m_hold && bus.out_ready) begin
        m_hold = 1'b0;
        m_mask = '0;
        m_delivered++;
`ifdef INSERTUNIT_ZERO_FILL_EN
        for (int i = 0; i < int'(K); i++) m_lanes[i] = '0;
`endif
      end
    end
  endtask

  task automatic chk(input string tag, input logic [K*W-1:0] obs, input logic [K*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("out_valid", K*W'(bus.out_valid), K*W'(m_hold));
    chk("in_ready",  K*W'(bus.in_ready),  K*W'(!m_hold));
    chk("out_mask",  K*W'(bus.out_mask),  K*W'(m_mask));
    chk("out_data",  bus.out_data,        m_vec());
    chk("err_oob",   K*W'(bus.err_oob),   K*W'(m_err));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare at the falling edge.
  task automatic cyc(input logic v, input logic [31:0] d, input logic [31:0] idx,
                     input logic b, input logic l, input logic ordy, input logic rs);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_index  = idx;
    bus.in_bcast  = b;
    bus.in_last   = l;
    bus.out_ready = ordy;
    reset         = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_model();
  endtask

  logic [K*W-1:0] exp_v;

  initial begin
    checks = 0;
    errors = 0;
    m_delivered = 0;
    m_hold = 1'b0;
    m_mask = '0;
    m_err  = 1'b0;
    for (int i = 0; i < int'(K); i++) m_lanes[i] = '0;

    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("reset_data", bus.out_data, '0);
    chk("reset_rdy",  K*W'(bus.in_ready), K*W'(1));

    // Two sparse lane writes, then stall the consumer.
    cyc(1, 32'hAAAA0002, 2, 0, 0, 0, 0);
    cyc(1, 32'h11110000, 0, 0, 1, 0, 0);
    exp_v = {32'h0, 32'hAAAA0002, 32'h0, 32'h11110000};
    chk("vec1_mask", K*W'(bus.out_mask), K*W'(4'b0101));
    chk("vec1_data", bus.out_data, exp_v);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h12345678, 1, 0, 1, 0, 0);
      chk("vec1_stall", bus.out_data, exp_v);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("vec1_done", K*W'(bus.in_ready), K*W'(1));

    // Broadcast, then a single-lane vector showing merge or zero-fill.
    cyc(1, 32'hDEADBEEF, 3, 1, 1, 0, 0);
    chk("bcast_mask", K*W'(bus.out_mask), K*W'(4'b1111));
    chk("bcast_data", bus.out_data, {K{32'hDEADBEEF}});
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 32'h5, 1, 0, 1, 0, 0);
`ifdef INSERTUNIT_ZERO_FILL_EN
    exp_v = {32'h0, 32'h0, 32'h5, 32'h0};
`else
    exp_v = {32'hDEADBEEF, 32'hDEADBEEF, 32'h5, 32'hDEADBEEF};
`endif
    chk("lane1_mask", K*W'(bus.out_mask), K*W'(4'b0010));
    chk("lane1_data", bus.out_data, exp_v);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // Out-of-range closing word: error pulse, empty mask, buffer untouched.
    cyc(1, 32'hCAFEF00D, 7, 0, 1, 0, 0);
    chk("oob_err",  K*W'(bus.err_oob), K*W'(1));
    chk("oob_mask", K*W'(bus.out_mask), '0);
    chk("oob_vld",  K*W'(bus.out_valid), K*W'(1));
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("oob_pulse", K*W'(bus.err_oob), '0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // Reset while holding discards the vector.
    cyc(1, 32'h77, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_hold_vld", K*W'(bus.out_valid), '0);
    chk("rst_hold_rdy", K*W'(bus.in_ready), K*W'(1));
    chk("rst_hold_msk", K*W'(bus.out_mask), '0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom(), 32'($urandom_range(0, 5)),
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/insertunit.md
Name: insertunit

Overview:
- Scalar-to-vector counterpart of the lane select path. Accepts a stream of 32-bit scalar words, each tagged with a lane index, and assembles them into a K-lane vector in an internal buffer.
- Presents the completed vector to the vector register write path through a valid/ready handshake.
- Sits between the scalar unit result bus and the vector register file write port.

Parameters:
- K, 4, number of vector lanes; equals the project-wide lane constant.
- W, 32, lane width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  scalar word offered.
- in_ready  output  1  unit can accept a scalar word this cycle.
- in_data  input  W  scalar word.
- in_index  input  32  target lane number.
- in_bcast  input  1  write in_data to all K lanes; in_index ignored.
- in_last  input  1  this word closes the current vector.
- out_valid  output  1  assembled vector available.
- out_ready  input  1  consumer accepts the vector.
- out_data  output  K*W  vector; lane i at bits [i*W +: W].
- out_mask  output  K  lanes written since the vector was opened.
- err_oob  output  1  one-cycle pulse for an accepted word with in_index >= K and in_bcast=0.

Behaviour:
- States:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset (sync, active-high):
  - state=FILL, buffer=0, out_mask=0, err_oob=0.
  - out_valid=0, in_ready=1.
  - reset mid-HOLD discards the vector without a handshake.
- Accept when in_valid && in_ready. On accept:
  - in_bcast=1: all lanes <= in_data; out_mask <= all ones.
  - in_bcast=0, in_index<K: lane[in_index] <= in_data; out_mask[in_index] <= 1.
  - in_bcast=0, in_index>=K: buffer and mask unchanged; err_oob=1 next cycle. The word still counts for in_last.
  - A repeated write to the same lane overwrites it (last write wins).
- FILL->HOLD on accept with in_last=1, including the out-of-range case. The write and the transition happen on the same edge, so out_valid rises one cycle after the last accept.
- HOLD->FILL on out_valid && out_ready.
  - Same edge: out_mask <= 0; buffer retained (see optional feature).
  - in_ready returns to 1 the following cycle. There is no bypass, so the back-to-back vector rate is 1 vector per N+1 cycles minimum.
- out_data and out_mask stay stable while out_valid=1 and out_ready=0.
- Input words offered during HOLD are not accepted; the producer must hold in_valid and its data.
- A vector with zero in-range writes (in_last on an out-of-range word) is still emitted, with out_mask=0.
- err_oob is registered, high for exactly one cycle per offending accept.

Optional Feature:
- Macro: INSERTUNIT_ZERO_FILL_EN.
- Defined: on HOLD->FILL the buffer is cleared to 0. Lanes not written in the next vector read as 0.
- Undefined: buffer is retained, so unwritten lanes hold the previous vector's values (merge semantics). out_mask identifies the fresh lanes.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, out_mask=0, out_data=0, err_oob=0.
- K=4:
  - Write lane2=0xAAAA0002, then lane0=0x11110000 with in_last.
  - Next cycle: out_valid=1, out_mask=4'b0101, lane0=0x11110000, lane2=0xAAAA0002, lane1=lane3=0.
  - Hold out_ready=0 for 3 cycles: outputs unchanged, in_ready=0.
- Broadcast 0xDEADBEEF with in_last: out_mask=4'b1111, every lane 0xDEADBEEF.
- Second vector writes only lane1=0x5 with in_last:
  - With INSERTUNIT_ZERO_FILL_EN: lanes = {0, 0, 0x5, 0}.
  - Without: lanes 0/2/3 = 0xDEADBEEF, lane1 = 0x5.
  - out_mask=4'b0010 in both builds.
- in_index=7 (K=4) with in_last:
  - err_oob pulses 1 cycle.
  - Vector emitted with out_mask=0, buffer unchanged.
- Assert reset during HOLD with out_ready=0: next cycle out_valid=0, in_ready=1, out_mask=0, and no vector is delivered.
